duty_cycle_monitor: RTL and testbench
=====================================

DUTY_CYCLE_MONITOR -- requirements
Module: duty_cycle_monitor

Interface
REQ-001 The block SHALL take parameter CNT_W, default 8: width of the cycle accumulators and result outputs.
REQ-002 The block SHALL take parameter EXP_HIGH, default 6: expected high-time in clk cycles.
REQ-003 The block SHALL take parameter EXP_PERIOD, default 10: expected period in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: measurement enable, synchronous.
REQ-007 The block SHALL have port sig_in, input, 1 bit: monitored waveform, synchronous to clk (e.g. a divided duty-cycle clock output).
REQ-008 The block SHALL have port high_cnt, output, CNT_W bits: high cycles of the last complete period.
REQ-009 The block SHALL have port period_cnt, output, CNT_W bits: total cycles of the last complete period.
REQ-010 The block SHALL have port meas_valid, output, 1 bit: one-cycle pulse when high_cnt and period_cnt update.
REQ-011 The block SHALL have port duty_ok, output, 1 bit: the last result matched EXP_HIGH and EXP_PERIOD.
REQ-012 The block SHALL have port overflow_err, output, 1 bit: one-cycle pulse when the period accumulator saturates.

Function
REQ-013 sig_in SHALL be sampled every clk into register sig_d; a rising edge is sig_in=1 & sig_d=0, and a falling edge is sig_in=0 & sig_d=1.
REQ-014 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-015 In IDLE, accumulators SHALL hold 0; a rising edge SHALL move the FSM to HIGH with high_acc=1 and period_acc=1.
REQ-016 In HIGH with sig_in=1: high_acc+1 and period_acc+1.
REQ-017 In HIGH on a falling edge: period_acc+1 and go to LOW.
REQ-018 In LOW with sig_in=0: period_acc+1.
REQ-019 In LOW on a rising edge, the period SHALL complete.
REQ-020 On period completion: high_cnt<=high_acc and period_cnt<=period_acc are latched.
REQ-021 On period completion: meas_valid=1 on the following cycle (latency 1 clk after the edge sample).
REQ-022 On period completion: duty_ok<=(high_acc==EXP_HIGH && period_acc==EXP_PERIOD).
REQ-023 On period completion: high_acc=1 and period_acc=1, and the FSM goes to HIGH (back-to-back measurement, no dead period).
REQ-024 high_cnt, period_cnt and duty_ok SHALL hold their values between meas_valid pulses.
REQ-025 If period_acc equals 2^CNT_W-1 in HIGH or LOW and the period has not completed, the block SHALL pulse overflow_err for 1 cycle.
REQ-026 On that saturation, the block SHALL clear the accumulators and go to IDLE, leaving results unchanged.
REQ-027 Saturation SHALL cover a stuck-high and a stuck-low input alike.
REQ-028 If completion and saturation coincide, completion SHALL take priority and no overflow_err SHALL be raised.
REQ-029 en=0 SHALL force IDLE and clear the accumulators on the next clk, discarding any partial period.
REQ-030 en=0 SHALL NOT alter the held results; sig_d SHALL still sample.
REQ-031 The minimum measurable period SHALL be 2 (1 high, 1 low); results SHALL be unsigned with no wrap-around.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, accumulators 0, and high_cnt, period_cnt, meas_valid, duty_ok and overflow_err to 0.
REQ-033 reset_n=0 SHALL set sig_d to 1, so that an input already high at reset release is not taken as a rising edge.
REQ-034 After reset release, the first meas_valid SHALL occur only after two rising edges.
REQ-035 Reset asserted mid-period SHALL discard the partial measurement.

Verification
REQ-036 The bench SHALL drive a repeating pattern of 6 high / 4 low -> meas_valid one cycle after the 2nd rising edge, then every 10 cycles, with high_cnt=6, period_cnt=10, duty_ok=1.
REQ-037 The bench SHALL drive a repeating pattern of 5 high / 5 low -> high_cnt=5, period_cnt=10, duty_ok=0.
REQ-038 The bench SHALL toggle sig_in every cycle -> high_cnt=1, period_cnt=2, meas_valid every 2 cycles, duty_ok=0.
REQ-039 The bench SHALL drive one rising edge, then hold sig_in=1 -> overflow_err pulses once when period_acc reaches 255, the FSM returns to IDLE, and no meas_valid or further overflow_err occurs while the input stays high.
REQ-040 The bench SHALL assert reset_n=0 during HIGH of a 6/4 pattern -> all outputs 0 at once; after release, the first meas_valid follows the 2nd new rising edge with values 6/10.
REQ-041 The bench SHALL drop en for 3 cycles mid-period -> no meas_valid for that period, prior results held, and measurement resumes from the next rising edge after en=1.

Source files
------------

// File: rtl/duty_cycle_monitor.sv
// Measures high time and period of a clk-synchronous waveform between consecutive rising edges.
// Results, meas_valid and overflow_err are registered one clk after the sampled completing edge.
module duty_cycle_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_HIGH   = 6,
  parameter int EXP_PERIOD = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             duty_ok,
  output logic             overflow_err
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ACC_MAX    = '1;
  localparam logic [CNT_W-1:0] ACC_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_HIGH_C = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_PER_C  = CNT_W'(EXP_PERIOD);

  state_t           state_q, state_d;
  logic             sig_q;
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [CNT_W-1:0] period_acc_q, period_acc_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             duty_ok_q, duty_ok_d;
  logic             meas_valid_q, meas_valid_d;
  logic             ovf_q, ovf_d;
  logic             rise;

  assign rise = sig_in & ~sig_q;

  always_comb begin
    state_d      = state_q;
    high_acc_d   = high_acc_q;
    period_acc_d = period_acc_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    duty_ok_d    = duty_ok_q;
    meas_valid_d = 1'b0;
    ovf_d        = 1'b0;

    if (!en) begin
      state_d      = IDLE;
      high_acc_d   = '0;
      period_acc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          high_acc_d   = '0;
          period_acc_d = '0;
          if (rise) begin
            state_d      = HIGH;
            high_acc_d   = ACC_ONE;
            period_acc_d = ACC_ONE;
          end
        end
        HIGH: begin
          // sig_q is always 1 here, so sig_in=0 is exactly the falling edge
          if (period_acc_q == ACC_MAX) begin
            state_d      = IDLE;
            high_acc_d   = '0;
            period_acc_d = '0;
            ovf_d        = 1'b1;
          end else if (sig_in) begin
            high_acc_d   = high_acc_q + ACC_ONE;
            period_acc_d = period_acc_q + ACC_ONE;
          end else begin
            period_acc_d = period_acc_q + ACC_ONE;
            state_d      = LOW;
          end
        end
        LOW: begin
          // completion is checked first so a full-length period is still reported
          if (rise) begin
            high_cnt_d   = high_acc_q;
            period_cnt_d = period_acc_q;
            duty_ok_d    = (high_acc_q == EXP_HIGH_C) && (period_acc_q == EXP_PER_C);
            meas_valid_d = 1'b1;
            high_acc_d   = ACC_ONE;
            period_acc_d = ACC_ONE;
            state_d      = HIGH;
          end else if (period_acc_q == ACC_MAX) begin
            state_d      = IDLE;
            high_acc_d   = '0;
            period_acc_d = '0;
            ovf_d        = 1'b1;
          end else begin
            period_acc_d = period_acc_q + ACC_ONE;
          end
        end
        default: begin
          state_d      = IDLE;
          high_acc_d   = '0;
          period_acc_d = '0;
        end
      endcase
    end
  end

  // sig_q resets high so a level already high at release is not a rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sig_q        <= 1'b1;
      high_acc_q   <= '0;
      period_acc_q <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      duty_ok_q    <= 1'b0;
      meas_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sig_q        <= sig_in;
      high_acc_q   <= high_acc_d;
      period_acc_q <= period_acc_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      duty_ok_q    <= duty_ok_d;
      meas_valid_q <= meas_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign high_cnt     = high_cnt_q;
  assign period_cnt   = period_cnt_q;
  assign duty_ok      = duty_ok_q;
  assign meas_valid   = meas_valid_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_duty_cycle_monitor.sv
// Bench for duty_cycle_monitor: edge-timestamp reference model checked every cycle, plus literal checks.
module tb_duty_cycle_monitor;

  localparam int CNT_W = 8;
  localparam int MAXP  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             meas_valid, duty_ok, overflow_err;

  int checks = 0;
  int failures = 0;
  int mv_count = 0;
  int ovf_count = 0;

  duty_cycle_monitor #(.CNT_W(CNT_W), .EXP_HIGH(6), .EXP_PERIOD(10)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .sig_in       (sig_in),
    .high_cnt     (high_cnt),
    .period_cnt   (period_cnt),
    .meas_valid   (meas_valid),
    .duty_ok      (duty_ok),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  // Model: a measurement is the time from one rising edge to the next, with
  // high time being the distance to the first fall in between.
  int  cyc = 0, start_t = 0, fall_t = 0;
  bit  armed = 0, fell = 0, prev = 1;
  int  e_high = 0, e_period = 0;
  bit  e_ok = 0, e_valid = 0, e_ovf = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed = 0; fell = 0; prev = 1;
      e_high = 0; e_period = 0; e_ok = 0; e_valid = 0; e_ovf = 0;
    end else begin
      bit rise;
      cyc++;
      e_valid = 0;
      e_ovf   = 0;
      rise = sig_in && !prev;
      if (!en) begin
        armed = 0;
      end else if (armed && fell && rise) begin
        e_high   = fall_t - start_t;
        e_period = cyc - start_t;
        e_ok     = (e_high == 6) && (e_period == 10);
        e_valid  = 1;
        start_t  = cyc;
        fell     = 0;
      end else if (armed && (cyc - start_t) == MAXP) begin
        e_ovf = 1;
        armed = 0;
      end else if (!armed && rise) begin
        armed = 1; start_t = cyc; fell = 0;
      end else if (armed && !fell && !sig_in) begin
        fell = 1; fall_t = cyc;
      end
      prev = sig_in;
    end
  end

  always @(negedge clk) begin
    chk("cmp_high_cnt", int'(high_cnt), e_high);
    chk("cmp_period_cnt", int'(period_cnt), e_period);
    chk("cmp_meas_valid", int'(meas_valid), int'(e_valid));
    chk("cmp_duty_ok", int'(duty_ok), int'(e_ok));
    chk("cmp_overflow_err", int'(overflow_err), int'(e_ovf));
    if (meas_valid) mv_count++;
    if (overflow_err) ovf_count++;
  end

  task automatic drive_level(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sig_in = v;
    end
  endtask

  task automatic drive_pattern(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      drive_level(1'b1, hi);
      drive_level(1'b0, lo);
    end
  endtask

  task automatic clr_counts();
    #1;
    mv_count  = 0;
    ovf_count = 0;
  endtask

  task automatic chk_results(input string nm, input int h, input int p, input int ok);
    #1;
    chk({nm, "_high"}, int'(high_cnt), h);
    chk({nm, "_period"}, int'(period_cnt), p);
    chk({nm, "_duty_ok"}, int'(duty_ok), ok);
  endtask

  initial begin
    #600000;
    $display("FAIL timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_high", int'(high_cnt), 0);
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_ovf", int'(overflow_err), 0);
    reset_n = 1'b1;
    clr_counts();

    // 6/4: first result only after the second rising edge
    drive_pattern(6, 4, 1);
    #1 chk("first_no_valid", mv_count, 0);
    drive_level(1'b1, 1);
    @(negedge clk); #1;
    chk("first_valid_latency", int'(meas_valid), 1);
    chk_results("p64_first", 6, 10, 1);
    drive_level(1'b1, 4);
    drive_level(1'b0, 4);
    clr_counts();
    drive_pattern(6, 4, 3);
    #1 chk("p64_valid_count", mv_count, 3);
    chk_results("p64", 6, 10, 1);

    // 5/5
    drive_pattern(5, 5, 3);
    chk_results("p55", 5, 10, 0);

    // Toggle every cycle
    clr_counts();
    drive_pattern(1, 1, 6);
    #1 chk("toggle_valid_count", mv_count, 6);
    chk_results("toggle", 1, 2, 0);

    // Stuck high
    drive_level(1'b0, 3);
    drive_level(1'b1, 2);
    clr_counts();
    drive_level(1'b1, 300);
    #1;
    chk("stuck_hi_ovf_count", ovf_count, 1);
    chk("stuck_hi_valid_count", mv_count, 0);
    chk_results("stuck_hi_held", 1, 5, 0);

    // Stuck low
    drive_level(1'b0, 1);
    drive_level(1'b1, 1);
    clr_counts();
    drive_level(1'b0, 300);
    #1;
    chk("stuck_lo_ovf_count", ovf_count, 1);
    chk("stuck_lo_valid_count", mv_count, 0);

    // Reset during HIGH
    drive_pattern(6, 4, 2);
    drive_level(1'b1, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_high", int'(high_cnt), 0);
    chk("midrst_period", int'(period_cnt), 0);
    chk("midrst_duty_ok", int'(duty_ok), 0);
    chk("midrst_valid", int'(meas_valid), 0);
    chk("midrst_ovf", int'(overflow_err), 0);
    drive_level(1'b1, 2);
    reset_n = 1'b1;
    clr_counts();
    drive_level(1'b1, 2);
    drive_level(1'b0, 4);
    drive_pattern(6, 4, 1);
    #1 chk("postrst_no_valid", mv_count, 0);
    drive_level(1'b1, 2);
    #1 chk("postrst_valid_count", mv_count, 1);
    chk_results("postrst", 6, 10, 1);

    // en dropped mid-period
    drive_level(1'b1, 4);
    drive_level(1'b0, 4);
    drive_pattern(5, 5, 2);
    drive_level(1'b1, 1);
    drive_level(1'b1, 2);
    clr_counts();
    en = 1'b0;
    drive_level(1'b1, 3);
    en = 1'b1;
    drive_level(1'b1, 1);
    drive_level(1'b0, 4);
    drive_level(1'b1, 2);
    #1 chk("en_drop_no_valid", mv_count, 0);
    chk_results("en_drop_held", 5, 10, 0);
    drive_level(1'b1, 4);
    drive_level(1'b0, 4);
    drive_level(1'b1, 2);
    #1 chk("en_resume_valid", mv_count, 1);
    chk_results("en_resume", 6, 10, 1);

    // Randomized segments with occasional en drops, stuck levels and resets
    for (int s = 0; s < 60; s++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        drive_level(1'(sel), $urandom_range(250, 300));
      end else if (sel == 1) begin
        drive_level(1'b1, $urandom_range(250, 300));
      end else if (sel == 2) begin
        en = 1'b0;
        drive_level(1'($urandom_range(0, 1)), $urandom_range(1, 4));
        en = 1'b1;
      end else if (sel == 3) begin
        #2 reset_n = 1'b0;
        drive_level(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        reset_n = 1'b1;
      end else begin
        drive_pattern($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4));
      end
    end
    drive_level(1'b0, 5);

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
